// File: rtl/axis_unpack_if.sv
// Stream bundle for the word-to-byte unpacker: wide input side plus byte output side.
interface axis_unpack_if #(parameter int n = 4) ();
  logic [n*8-1:0] in_tdata;
  logic [n-1:0]   in_tkeep;
  logic           in_tlast;
  logic           in_tvalid;
  logic           in_tready;
  logic [7:0]     out_tdata;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready;

  modport slave (
    input  in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tvalid
  );

  modport master (
    output in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tvalid
  );
endinterface

// File: rtl/axis_unpack.sv
// AXI-Stream width downsizer: one n-byte word in, bytes 0..h out (h = top keep bit),
// with a same-cycle reload on the last byte so back-to-back words stream at 1 byte/clock.
module axis_unpack #(
  parameter int n = 4
) (
  input logic         aclk,
  input logic         aresetn,
  axis_unpack_if.slave axis
);
  localparam int IW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = $clog2(n + 1);

  logic [n-1:0][7:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [CW-1:0]     load_cnt;
  logic              in_xfer, out_xfer, cnt_one;

  // Byte count is set by the highest keep bit; holes below it are still emitted.
  always_comb begin
    load_cnt = '0;
    for (int k = 0; k < n; k++)
      if (axis.in_tkeep[k]) load_cnt = CW'(k + 1);
  end

  assign cnt_one        = (cnt_q == CW'(1));
  assign axis.in_tready = (cnt_q == '0) | (cnt_one & axis.out_tready);
  assign in_xfer        = axis.in_tvalid & axis.in_tready;
  assign out_xfer       = axis.out_tvalid & axis.out_tready;

  assign axis.out_tvalid = (cnt_q != '0);
  assign axis.out_tdata  = word_q[idx_q];
  assign axis.out_tlast  = last_q & cnt_one;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (in_xfer && load_cnt != '0) begin
      word_d = axis.in_tdata;
      idx_d  = '0;
      cnt_d  = load_cnt;
      last_d = axis.in_tlast;
    end else if (out_xfer) begin
      // A zero-keep word accepted alongside the final byte lands here and is dropped.
      if (cnt_one) begin
        cnt_d = '0;
        idx_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
endmodule
